sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_rr_arb2.sv | 31 +++
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM port arbiter: controller state and requester tags.
package sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // One in-flight read: valid bit plus the requester that owns the response.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the pointer picks the winner. After any grant the pointer names the other
// requester, so a busy requester cannot starve its neighbour.
module sram_rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_id_t ptr;

  // Combinational grant, suppressed entirely when not enabled.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant[ptr] = 1'b1;
      else                grant      = valid;
    end
  end

  // Pointer moves past the requester just served; holds when idle.
  always_ff @(posedge clk) begin
    if (rst)        ptr <= REQ0;
    else if (|grant) ptr <= grant[1] ? REQ0 : REQ1;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between two requesters. After reset the
// whole array is cleared to zero, then commands are arbitrated round-robin,
// registered onto the macro pins, and read data is returned two cycles after
// acceptance to whichever requester issued the read.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [1:0]              grant;
  logic                    acc;
  req_id_t                 gid;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  rd_tag_t [2:1]           rd_pipe;

  sram_rr_arb2 u_arb (
    .clk   (clk0),
    .rst   (rst0),
    .en    (state == ST_RUN),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign acc        = |grant;
  assign gid        = grant[1] ? REQ1 : REQ0;
  assign init_done  = (state == ST_RUN);

  // Next state: leave INIT on the edge that registers the last clear write.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == LAST_ADDR) state_nxt = ST_RUN;
  end

  // State register and clear-address counter.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  // Select the granted requester's command fields.
  always_comb begin
    cmd_we    = req0_we;
    cmd_addr  = req0_addr;
    cmd_wdata = req0_wdata;
    if (grant[1]) begin
      cmd_we    = req1_we;
      cmd_addr  = req1_addr;
      cmd_wdata = req1_wdata;
    end
  end

  // Macro pins: clear writes in INIT, accepted commands in RUN, else idle
  // with address/data parked at their last values.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (state == ST_INIT) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b0;
      sram_addr0 <= init_cnt;
      sram_din0  <= '0;
    end else if (acc) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= ~cmd_we;
      sram_addr0 <= cmd_addr;
      sram_din0  <= cmd_wdata;
    end else begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
    end
  end

  // Read tag pipeline: stage 1 is the macro access cycle, stage 2 the cycle
  // the macro drives dout.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[1] <= '{vld: acc & ~cmd_we, id: gid};
      rd_pipe[2] <= rd_pipe[1];
    end
  end

  // Capture macro data into the owning requester's response; data holds otherwise.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd_pipe[2].vld && (rd_pipe[2].id == REQ0);
      rsp1_valid <= rd_pipe[2].vld && (rd_pipe[2].id == REQ1);
      if (rd_pipe[2].vld && rd_pipe[2].id == REQ0) rsp0_rdata <= sram_dout0;
      if (rd_pipe[2].vld && rd_pipe[2].id == REQ1) rsp1_rdata <= sram_dout0;
    end
  end

endmodule
